// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, stall-vector constants and jump-FSM state type for the pipeline controller.
package pipe_ctrl_pkg;

  localparam int unsigned RADDR_WIDTH = 5;
  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned STALL_W     = 6;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam logic [ADDR_WIDTH-1:0]  ZERO     = '0;
  localparam logic [RADDR_WIDTH-1:0] ZERO_REG = '0;

  // Bit 0 = pc, 1 = if_id, 2 = id_exe input, 3 = exe, 4 = mem, 5 = wb
  localparam logic [STALL_W-1:0] STALL_NONE    = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_LOADUSE = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_DIV     = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM     = 6'b011111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } jump_state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use comparator: EXE load destination against ID source operands.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                   ex_is_load_i,
  input  logic [RADDR_WIDTH-1:0] ex_rd_i,
  input  logic [RADDR_WIDTH-1:0] id_rs1_i,
  input  logic [RADDR_WIDTH-1:0] id_rs2_i,
  input  logic                   id_rs1_re_i,
  input  logic                   id_rs2_re_i,
  output logic                   hazard_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_rs1_re_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit  = id_rs2_re_i && (id_rs2_i == ex_rd_i);
  // x0 never carries a real dependency
  assign hazard_o = ex_is_load_i && (ex_rd_i != ZERO_REG) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall vector priority, deferred-jump FSM, bus timeout flag
// and stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ex_is_load_i,
  input  logic [RADDR_WIDTH-1:0] ex_rd_i,
  input  logic [RADDR_WIDTH-1:0] id_rs1_i,
  input  logic [RADDR_WIDTH-1:0] id_rs2_i,
  input  logic                   id_rs1_re_i,
  input  logic                   id_rs2_re_i,
  input  logic                   jump_req_i,
  input  logic [ADDR_WIDTH-1:0]  jump_addr_i,
  input  logic                   div_busy_i,
  input  logic                   mem_wait_i,
  output logic [STALL_W-1:0]     stall_o,
  output logic                   flush_jump_o,
  output logic                   jump_o,
  output logic [ADDR_WIDTH-1:0]  jump_addr_o,
  output logic                   bus_err_o,
  output logic [CNT_W-1:0]       stall_cnt_o,
  output logic [CNT_W-1:0]       flush_cnt_o
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  jump_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  bus_err_q, bus_err_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
  logic                  load_use;

  hazard_detect u_hazard_detect (
    .ex_is_load_i (ex_is_load_i),
    .ex_rd_i      (ex_rd_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_rs1_re_i  (id_rs1_re_i),
    .id_rs2_re_i  (id_rs2_re_i),
    .hazard_o     (load_use)
  );

  // Jump issue / deferral; outputs are same-cycle so the redirect is not delayed
  always_comb begin
    state_d      = state_q;
    pend_addr_d  = pend_addr_q;
    flush_jump_o = 1'b0;
    jump_o       = 1'b0;
    jump_addr_o  = ZERO;
    case (state_q)
      ST_IDLE: begin
        if (jump_req_i) begin
          if (!mem_wait_i) begin
            flush_jump_o = 1'b1;
            jump_o       = 1'b1;
            jump_addr_o  = jump_addr_i;
          end else begin
            state_d     = ST_PEND;
            pend_addr_d = jump_addr_i;
          end
        end
      end
      ST_PEND: begin
        if (!mem_wait_i) begin
          flush_jump_o = 1'b1;
          jump_o       = 1'b1;
          jump_addr_o  = pend_addr_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_o = STALL_NONE;
    if (flush_jump_o)     stall_o = STALL_NONE;
    else if (mem_wait_i)  stall_o = STALL_MEM;
    else if (div_busy_i)  stall_o = STALL_DIV;
    else if (load_use)    stall_o = STALL_LOADUSE;
  end

  // Timeout saturates at TIMEOUT; the error flag is sticky until reset
  always_comb begin
    tmo_d       = '0;
    bus_err_d   = bus_err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (mem_wait_i) begin
      tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);
    end
    if (mem_wait_i && (tmo_d == TMO_MAX)) bus_err_d = 1'b1;
    if (stall_o[0] == STOP) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_jump_o)       flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      pend_addr_q <= ZERO;
      tmo_q       <= '0;
      bus_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      tmo_q       <= tmo_d;
      bus_err_q   <= bus_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus_err_o   = bus_err_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: load-use, divide, immediate/deferred jumps,
// bus timeout and reset during a pending jump.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   ex_is_load_i;
  logic [RADDR_WIDTH-1:0] ex_rd_i;
  logic [RADDR_WIDTH-1:0] id_rs1_i;
  logic [RADDR_WIDTH-1:0] id_rs2_i;
  logic                   id_rs1_re_i;
  logic                   id_rs2_re_i;
  logic                   jump_req_i;
  logic [ADDR_WIDTH-1:0]  jump_addr_i;
  logic                   div_busy_i;
  logic                   mem_wait_i;
  logic [STALL_W-1:0]     stall_o;
  logic                   flush_jump_o;
  logic                   jump_o;
  logic [ADDR_WIDTH-1:0]  jump_addr_o;
  logic                   bus_err_o;
  logic [31:0]            stall_cnt_o;
  logic [31:0]            flush_cnt_o;

  int errors = 0;
  int checks = 0;

  pipe_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ex_is_load_i (ex_is_load_i),
    .ex_rd_i      (ex_rd_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_rs1_re_i  (id_rs1_re_i),
    .id_rs2_re_i  (id_rs2_re_i),
    .jump_req_i   (jump_req_i),
    .jump_addr_i  (jump_addr_i),
    .div_busy_i   (div_busy_i),
    .mem_wait_i   (mem_wait_i),
    .stall_o      (stall_o),
    .flush_jump_o (flush_jump_o),
    .jump_o       (jump_o),
    .jump_addr_o  (jump_addr_o),
    .bus_err_o    (bus_err_o),
    .stall_cnt_o  (stall_cnt_o),
    .flush_cnt_o  (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic jump_outs(input string tag, input logic j, input logic [31:0] a);
    chk({tag, "_jump"}, 32'(jump_o), 32'(j));
    chk({tag, "_flush"}, 32'(flush_jump_o), 32'(j));
    chk({tag, "_addr"}, jump_addr_o, a);
  endtask

  initial begin
    rst_i = 1'b1;
    ex_is_load_i = 1'b0; ex_rd_i = '0; id_rs1_i = '0; id_rs2_i = '0;
    id_rs1_re_i = 1'b0; id_rs2_re_i = 1'b0;
    jump_req_i = 1'b0; jump_addr_i = '0; div_busy_i = 1'b0; mem_wait_i = 1'b0;
    step(); step();
    jump_outs("rst", 1'b0, 32'h0);
    chk("rst_stall", 32'(stall_o), 32'h00);
    chk("rst_bus_err", 32'(bus_err_o), 32'h0);
    chk("rst_stall_cnt", stall_cnt_o, 32'd0);
    chk("rst_flush_cnt", flush_cnt_o, 32'd0);
    rst_i = 1'b0;

    // Load-use on rs2
    ex_is_load_i = 1'b1; ex_rd_i = 5'd5; id_rs2_i = 5'd5; id_rs2_re_i = 1'b1; #1;
    chk("lu_stall", 32'(stall_o), 32'h07);
    step();
    chk("lu_cnt", stall_cnt_o, 32'd1);
    ex_rd_i = 5'd0; id_rs2_i = 5'd0; #1;
    chk("lu_x0", 32'(stall_o), 32'h00);
    ex_rd_i = 5'd7; id_rs1_i = 5'd7; id_rs2_i = 5'd3; id_rs1_re_i = 1'b0; #1;
    chk("lu_rs1_noread", 32'(stall_o), 32'h00);
    step();
    ex_is_load_i = 1'b0; id_rs2_re_i = 1'b0; ex_rd_i = '0; id_rs1_i = '0; id_rs2_i = '0;

    // Divide for 8 cycles
    div_busy_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 chk($sformatf("div_stall_%0d", i), 32'(stall_o), 32'h0F);
      step();
    end
    chk("div_cnt", stall_cnt_o, 32'd9);

    // Immediate jump beats divide and load-use
    ex_is_load_i = 1'b1; ex_rd_i = 5'd4; id_rs1_i = 5'd4; id_rs1_re_i = 1'b1;
    jump_req_i = 1'b1; jump_addr_i = 32'h8000_0040; #1;
    jump_outs("imm", 1'b1, 32'h8000_0040);
    chk("imm_stall", 32'(stall_o), 32'h00);
    step();
    chk("imm_flush_cnt", flush_cnt_o, 32'd1);
    chk("imm_stall_cnt", stall_cnt_o, 32'd9);
    jump_req_i = 1'b0; div_busy_i = 1'b0; ex_is_load_i = 1'b0; id_rs1_re_i = 1'b0; #1;
    jump_outs("imm_after", 1'b0, 32'h0);
    step();

    // Deferred jump with a dropped second request
    mem_wait_i = 1'b1; jump_req_i = 1'b1; jump_addr_i = 32'h100; #1;
    jump_outs("def_req1", 1'b0, 32'h0);
    chk("def_stall", 32'(stall_o), 32'h1F);
    step();
    jump_addr_i = 32'h200; #1;
    jump_outs("def_req2", 1'b0, 32'h0);
    step();
    jump_req_i = 1'b0; jump_addr_i = '0; #1;
    jump_outs("def_wait", 1'b0, 32'h0);
    step();
    mem_wait_i = 1'b0; #1;
    jump_outs("def_issue", 1'b1, 32'h100);
    chk("def_issue_stall", 32'(stall_o), 32'h00);
    step();
    jump_outs("def_done", 1'b0, 32'h0);
    chk("def_flush_cnt", flush_cnt_o, 32'd2);
    chk("def_stall_cnt", stall_cnt_o, 32'd12);
    chk("def_bus_err", 32'(bus_err_o), 32'h0);

    // Timeout: 3 waits, gap, 4 waits
    mem_wait_i = 1'b1;
    repeat (3) step();
    chk("tmo_burst1", 32'(bus_err_o), 32'h0);
    mem_wait_i = 1'b0; step();
    mem_wait_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("tmo_b2_%0d", i + 1), 32'(bus_err_o), 32'h0);
    end
    step();
    chk("tmo_set", 32'(bus_err_o), 32'h1);
    mem_wait_i = 1'b0; step(); step();
    chk("tmo_sticky", 32'(bus_err_o), 32'h1);
    chk("tmo_stall_cnt", stall_cnt_o, 32'd19);
    chk("tmo_flush_cnt", flush_cnt_o, 32'd2);

    // Reset while a jump is pending
    mem_wait_i = 1'b1; jump_req_i = 1'b1; jump_addr_i = 32'h300;
    step();
    jump_req_i = 1'b0; jump_addr_i = '0;
    #2 rst_i = 1'b1; #1;
    chk("rstp_stall_cnt", stall_cnt_o, 32'd0);
    chk("rstp_flush_cnt", flush_cnt_o, 32'd0);
    chk("rstp_bus_err", 32'(bus_err_o), 32'h0);
    chk("rstp_stall_follow", 32'(stall_o), 32'h1F);
    mem_wait_i = 1'b0; #1;
    jump_outs("rstp_drop", 1'b0, 32'h0);
    step();
    rst_i = 1'b0;
    step();
    jump_outs("rstp_after", 1'b0, 32'h0);
    chk("rstp_flush_after", flush_cnt_o, 32'd0);
    chk("rstp_stall_after", stall_cnt_o, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline control unit for the five-stage core. It issues the 6-bit `stall_o` vector and the `flush_jump_o` pulse that every stage register, including the ID/EXE register, consumes. It detects load-use hazards from the EXE-stage load/rd sideband, freezes the pipe for multi-cycle divide and memory waits, and defers jumps that arrive while the pipe is frozen. It also keeps stall/flush performance counters and a sticky bus-timeout flag.

## Interface
- `TIMEOUT`, 256: consecutive `mem_wait_i` cycles after which `bus_err_o` sets.
- `CNT_W`, 32: width of the performance counters.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous and active-high.
- `ex_is_load_i` in 1: EXE-stage instruction is a load (from the ID/EXE register).
- `ex_rd_i` in `RADDR_WIDTH`: EXE-stage destination register.
- `id_rs1_i`, `id_rs2_i` in `RADDR_WIDTH` each: ID-stage source registers.
- `id_rs1_re_i`, `id_rs2_re_i` in 1 each: ID-stage source-read enables.
- `jump_req_i` in 1: single-cycle jump/taken-branch pulse from EXE.
- `jump_addr_i` in `ADDR_WIDTH`: jump target, valid with `jump_req_i`.
- `div_busy_i` in 1: EXE multi-cycle divider busy.
- `mem_wait_i` in 1: MEM-stage bus not ready.
- `stall_o` out 6: per-stage stop. Bit 0 = pc, 1 = if_id, 2 = id_exe input, 3 = exe, 4 = mem, 5 = wb. `STOP`=1.
- `flush_jump_o` out 1: flush the IF/ID and ID/EXE registers.
- `jump_o` out 1: load the PC with `jump_addr_o`.
- `jump_addr_o` out `ADDR_WIDTH`: redirect target.
- `bus_err_o` out 1: sticky bus-timeout flag.
- `stall_cnt_o` out `CNT_W`: number of cycles with `stall_o[0]`=1.
- `flush_cnt_o` out `CNT_W`: number of flush events.

## Operation
- Load-use hazard condition: `ex_is_load_i` and `ex_rd_i`≠0 and ((`id_rs1_re_i` and `id_rs1_i`==`ex_rd_i`) or (`id_rs2_re_i` and `id_rs2_i`==`ex_rd_i`)).
- `stall_o` priority, highest first:
  - Flush issued this cycle: `stall_o`=000000.
  - `mem_wait_i`=1: `stall_o`=011111.
  - `div_busy_i`=1: `stall_o`=001111.
  - Load-use hazard: `stall_o`=000111. This inserts one bubble, because the ID/EXE register sees id stopped and exe running.
  - Otherwise: `stall_o`=000000.
- Jump handling, two states:
  - IDLE:
    - `jump_req_i` with `mem_wait_i`=0: drive `jump_o`=`flush_jump_o`=1 and `jump_addr_o`=`jump_addr_i` combinationally.
    - `jump_req_i` with `mem_wait_i`=1: latch the address and go to PEND. No flush this cycle.
  - PEND:
    - Outputs 0 while `mem_wait_i`=1.
    - First cycle with `mem_wait_i`=0: `jump_o`=`flush_jump_o`=1, `jump_addr_o`=the latched address, return to IDLE.
    - `jump_req_i` while in PEND is dropped; the latched address is kept.
- A jump beats `div_busy_i` and the load-use hazard in the same cycle.
- Timeout counter:
  - Counts consecutive `mem_wait_i` cycles, saturating at `TIMEOUT`.
  - Clears when `mem_wait_i`=0.
  - When it reaches `TIMEOUT`, `bus_err_o` sets and stays 1 until reset. Stalling is unaffected.
- Performance counters:
  - `stall_cnt_o` increments on each edge where `stall_o[0]`=1.
  - `flush_cnt_o` increments on each edge where `flush_jump_o`=1.
  - Both wrap modulo 2^`CNT_W`.

## Timing
- `stall_o`, `flush_jump_o`, `jump_o` and `jump_addr_o` are combinational in the same cycle; consumers sample them at the next `clk_i` rising edge.
- A deferred jump leaves the pipe exactly one cycle after `mem_wait_i` falls, in the cycle where `mem_wait_i` reads 0.
- Reset values:
  - State = IDLE, latched address = 0.
  - Counters = 0, `bus_err_o`=0, timeout counter = 0.
  - Resulting outputs: `jump_o`=`flush_jump_o`=0, `jump_addr_o`=0.
  - While `rst_i` is high, `stall_o` still follows its combinational inputs.
- `rst_i` asserted while in PEND discards the pending jump immediately, asynchronously.
- `bus_err_o` rises on the edge that ends the `TIMEOUT`-th consecutive wait cycle.

## Structure
- `defines.v` supplies `RADDR_WIDTH`, `ADDR_WIDTH`, `STOP`/`NOSTOP`, `ZERO` and `ZERO_REG`.
- Add the stall-vector constants to `defines.v`: `STALL_NONE`, `STALL_LOADUSE`=000111, `STALL_DIV`=001111, `STALL_MEM`=011111.
- One sub-module, `hazard_detect`: the purely combinational load-use comparator. Everything else lives in `pipe_ctrl`.

## Test plan
- Load-use: `ex_is_load_i`=1, `ex_rd_i`=5, `id_rs2_i`=5, `id_rs2_re_i`=1 → `stall_o`=000111 for 1 cycle. With `ex_rd_i`=0 → `stall_o`=000000.
- Divide: `div_busy_i` high for 8 cycles → `stall_o`=001111 for 8 cycles, `stall_cnt_o`=8.
- Immediate jump: `jump_req_i` pulse, addr 0x80000040 → same cycle `jump_o`=`flush_jump_o`=1, `jump_addr_o`=0x80000040, `stall_o`=0, `flush_cnt_o`=1.
- Deferred jump: `jump_req_i` to 0x100 during `mem_wait_i`=1, a second `jump_req_i` to 0x200 while still waiting, `mem_wait_i` drops 3 cycles later → single flush with `jump_addr_o`=0x100.
- Timeout: `TIMEOUT`=4, `mem_wait_i` high for 3 cycles, low, then high for 4 cycles → `bus_err_o`=1 only after the 4th cycle of the second burst, and it stays 1.
- Reset mid-PEND: assert `rst_i` asynchronously → no flush afterwards, counters = 0.
